// File: rtl/sram_arbiter2.sv
// rtl/sram_arbiter2.sv - two-port arbiter/sequencer for the 16x128 single-port SRAM
// Define SRAM_ARB_RR_EN for round-robin ties; otherwise port 0 has fixed priority.
module sram_arbiter2 #(
  parameter int DW = 16,
  parameter int AW = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o,
  output logic          busy_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  input  logic [DW-1:0] mem_dout_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          win_q, win_d;  // 1 = port 1 owns the access in flight
  logic          rd_q, rd_d;
  logic          pick1;
  logic          pick_we;
`ifdef SRAM_ARB_RR_EN
  logic          last_q, last_d;  // 1 = port 1 was granted last
`endif

  always_comb begin
    state_d    = state_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    win_d      = win_q;
    rd_d       = rd_q;
`ifdef SRAM_ARB_RR_EN
    last_d     = last_q;
    pick1      = req1_i & (~req0_i | ~last_q);
`else
    pick1      = req1_i & ~req0_i;
`endif
    pick_we    = pick1 ? we1_i : we0_i;

    case (state_q)
      S_IDLE: begin
        if (req0_i | req1_i) begin
          gnt0_d     = ~pick1;
          gnt1_d     = pick1;
          mem_addr_d = pick1 ? addr1_i : addr0_i;
          mem_din_d  = pick1 ? wdata1_i : wdata0_i;
          mem_we_d   = pick_we;
          mem_re_d   = ~pick_we;
          win_d      = pick1;
          rd_d       = ~pick_we;
`ifdef SRAM_ARB_RR_EN
          last_d     = pick1;
`endif
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // SRAM output is only valid before this edge; capture it now.
        if (rd_q) begin
          if (win_q) begin
            rdata1_d  = mem_dout_i;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_dout_i;
            rvalid0_d = 1'b1;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      win_q      <= 1'b0;
      rd_q       <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      win_q      <= win_d;
      rd_q       <= rd_d;
`ifdef SRAM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign rvalid0_o  = rvalid0_q;
  assign rvalid1_o  = rvalid1_q;
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;
  assign busy_o     = (state_q != S_IDLE);
  assign mem_we_o   = mem_we_q;
  assign mem_re_o   = mem_re_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;

endmodule

// File: tb/tb_sram_arbiter2.sv
// tb/tb_sram_arbiter2.sv - directed bench for sram_arbiter2 with a behavioural SRAM
// Tie-order expectations follow SRAM_ARB_RR_EN when it is defined for the build.
module tb_sram_arbiter2;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [6:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_we, mem_re;
  logic [15:0] rdata0, rdata1, mem_din, mem_dout;
  logic [6:0]  mem_addr;
  logic [15:0] sram [128];
  logic [15:0] shadow [128];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  sram_arbiter2 #(.DW(16), .AW(7)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .busy_o(busy),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  // Single-port SRAM: write or read-latch on the edge, output zeroed when idle.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    if (mem_re) mem_dout <= sram[mem_addr];
    else        mem_dout <= 16'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input int p, input logic w, input logic [6:0] a,
                       input logic [15:0] d, output bit ok);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((p == 0 && gnt0) || (p == 1 && gnt1)) begin ok = 1'b1; break; end
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [74:0] outs;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    outs = {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, mem_we, mem_re, mem_addr, mem_din};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
  endtask

  task automatic test_write_read();
    bit ok;
    issue(0, 1'b1, 7'h05, 16'hA5A5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_grant got timeout want gnt0"); end
    checks++; if ({mem_we, mem_re} !== 2'b10) begin errors++; $display("FAIL wr_strobes got %b want 10", {mem_we, mem_re}); end
    checks++; if (mem_addr !== 7'h05) begin errors++; $display("FAIL wr_addr got %h want 05", mem_addr); end
    checks++; if (mem_din !== 16'hA5A5) begin errors++; $display("FAIL wr_din got %h want a5a5", mem_din); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy); end
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    issue(0, 1'b0, 7'h05, 16'h0, ok);
    checks++; if (!ok || {mem_we, mem_re} !== 2'b01) begin errors++; $display("FAIL rd_grant got ok=%0d we/re=%b want 1 01", ok, {mem_we, mem_re}); end
    step();
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid got %b want 0", rvalid0); end
    step();
    checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b want 1", rvalid0); end
    checks++; if (rdata0 !== 16'hA5A5) begin errors++; $display("FAIL rd_data got %h want a5a5", rdata0); end
    step();
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_rvalid_clear got %b want 0", rvalid0); end
    checks++; if (rdata0 !== 16'hA5A5) begin errors++; $display("FAIL rd_data_hold got %h want a5a5", rdata0); end
  endtask

  task automatic test_port1();
    bit ok;
    issue(1, 1'b0, 7'h7F, 16'h0, ok);
    checks++; if (!ok || mem_addr !== 7'h7F) begin errors++; $display("FAIL p1_grant got ok=%0d addr=%h want 1 7f", ok, mem_addr); end
    step();
    step();
    checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL p1_rvalid got %b%b want 10", rvalid1, rvalid0); end
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL p1_data got %h want 0", rdata1); end
    checks++; if (rdata0 !== 16'hA5A5) begin errors++; $display("FAIL p1_rdata0_kept got %h want a5a5", rdata0); end
    step();
  endtask

  task automatic test_simultaneous();
    int got [4];
    int n = 0;
    int expv;
    foreach (got[k]) got[k] = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h21;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (gnt0 && gnt1) begin
        checks++; errors++; $display("FAIL sim_both_gnt got 11 want one-hot");
      end else if (gnt0) begin got[n] = 0; n++; end
      else if (gnt1) begin got[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL sim_grant_count got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
      expv = k % 2;
`else
      expv = 0;
`endif
      checks++;
      if (got[k] != expv) begin errors++; $display("FAIL sim_order[%0d] got %0d want %0d", k, got[k], expv); end
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_back_to_back();
    int g1 = -1, g2 = -1, extra = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h30; wdata0 = 16'h1111;
    for (int i = 0; i < 20; i++) begin step(); if (gnt0) begin g1 = cyc; break; end end
    addr0 = 7'h31; wdata0 = 16'h2222;
    for (int i = 0; i < 20; i++) begin step(); if (gnt0) begin g2 = cyc; break; end end
    req0 = 1'b0;
    checks++; if (g1 < 0 || g2 < 0 || g2 - g1 != 3) begin errors++; $display("FAIL b2b_gap got %0d want 3", g2 - g1); end
    checks++; if (mem_addr !== 7'h31) begin errors++; $display("FAIL b2b_addr got %h want 31", mem_addr); end
    for (int i = 0; i < 6; i++) begin step(); if (gnt0) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_extra_gnt got %0d want 0", extra); end
    checks++; if (sram[7'h30] !== 16'h1111) begin errors++; $display("FAIL b2b_mem30 got %h want 1111", sram[7'h30]); end
    checks++; if (sram[7'h31] !== 16'h2222) begin errors++; $display("FAIL b2b_mem31 got %h want 2222", sram[7'h31]); end
  endtask

  task automatic test_random();
    bit act0 = 0, act1 = 0, pend0 = 0, pend1 = 0;
    logic [15:0] exp0 = '0, exp1 = '0;
    int viol = 0, nrd = 0;
    foreach (sram[k]) shadow[k] = sram[k];
    for (int t = 0; t < 1000; t++) begin
      step();
      if (mem_we & mem_re) viol++;
      if (gnt0) begin
        if (we0) shadow[addr0] = wdata0; else begin exp0 = shadow[addr0]; pend0 = 1; end
        act0 = 0; req0 = 1'b0;
      end
      if (gnt1) begin
        if (we1) shadow[addr1] = wdata1; else begin exp1 = shadow[addr1]; pend1 = 1; end
        act1 = 0; req1 = 1'b0;
      end
      if (rvalid0) begin
        checks++; nrd++;
        if (!pend0 || rdata0 !== exp0) begin errors++; $display("FAIL rnd_rdata0 got %h want %h pend=%0d", rdata0, exp0, pend0); end
        pend0 = 0;
      end
      if (rvalid1) begin
        checks++; nrd++;
        if (!pend1 || rdata1 !== exp1) begin errors++; $display("FAIL rnd_rdata1 got %h want %h pend=%0d", rdata1, exp1, pend1); end
        pend1 = 0;
      end
      if (!act0 && $urandom_range(0, 1) == 1) begin
        act0 = 1; req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = 7'h20 + 7'($urandom_range(0, 15)); wdata0 = 16'($urandom);
      end
      if (!act1 && $urandom_range(0, 1) == 1) begin
        act1 = 1; req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = 7'h20 + 7'($urandom_range(0, 15)); wdata1 = 16'($urandom);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (viol != 0) begin errors++; $display("FAIL rnd_we_re_overlap got %0d want 0", viol); end
    checks++; if (nrd == 0) begin errors++; $display("FAIL rnd_reads got %0d want >0", nrd); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    logic [74:0] outs;
    int stray = 0;
    issue(0, 1'b0, 7'h05, 16'h0, ok);
    step();
    step();
    checks++; if (!ok || rdata0 !== 16'hA5A5) begin errors++; $display("FAIL mid_preload got %h want a5a5", rdata0); end
    step();
    issue(0, 1'b0, 7'h05, 16'h0, ok);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    outs = {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, mem_we, mem_re, mem_addr, mem_din};
    checks++;
    if (!ok || outs !== '0) begin errors++; $display("FAIL mid_reset_outputs got %h ok=%0d want 0", outs, ok); end
    for (int i = 0; i < 5; i++) begin step(); if (rvalid0 || rvalid1 || busy) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_stray_activity got %0d want 0", stray); end
  endtask

  initial begin
    foreach (sram[k]) sram[k] = 16'h0;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write_read();
    test_port1();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
